// File: rtl/pcie_dll_pkg.sv
// Shared definitions for the PCIe data-link-layer replay transmitter:
// DLLP type codes, DLLP field positions and the replay state encoding.
package pcie_dll_pkg;

    localparam logic [7:0] DLLP_ACK      = 8'h00;
    localparam logic [7:0] DLLP_NAK      = 8'h10;
    localparam int         DLLP_TYPE_LSB = 24;
    localparam int         DLLP_TYPE_W   = 8;
    localparam int         DLLP_SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        REPLAY  = 2'd1,
        RETRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pcie_replay_ram.sv
// Replay buffer storage: DEPTH x DATA_W, synchronous write, combinational read.
// Sequence numbers are not stored; the controller recomputes them.
module pcie_replay_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pcie_dll_replay_tx.sv
// PCIe DLL transmit stage: sequence numbering, replay buffer, ACK/NAK handling,
// replay timer and retrain escalation. Optional statistics: PCIE_REPLAY_STAT_EN.
module pcie_dll_replay_tx
    import pcie_dll_pkg::*;
#(
    parameter int DATA_W     = 1024,
    parameter int DEPTH      = 8,
    parameter int SEQ_W      = 12,
    parameter int TIMEOUT    = 256,
    parameter int MAX_REPLAY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        tlp_data_i,
    input  logic                     tlp_valid_i,
    output logic                     tlp_ready_o,
    output logic [DATA_W-1:0]        link_data_o,
    output logic [SEQ_W-1:0]         link_seq_o,
    output logic                     link_valid_o,
    input  logic                     link_ready_i,
    input  logic [31:0]              dllp_i,
    input  logic                     dllp_valid_i,
    output logic                     retrain_req_o,
    input  logic                     retrain_done_i,
    output logic                     replay_active_o,
    output logic                     dllp_err_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef PCIE_REPLAY_STAT_EN
    ,
    output logic [15:0]              replay_cnt_o,
    output logic [15:0]              timeout_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_REPLAY + 1) + 1;

    state_t            state_r, state_n;
    logic [SEQ_W-1:0]  next_seq_r, acked_seq_r, acked_seq_n;
    logic [CW-1:0]     count_r, count_n, offset_r, offset_n;
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, rd_ptr_p_s, raddr_s;
    logic [TW-1:0]     timer_r, timer_n;
    logic [RW-1:0]     replay_num_r, replay_num_n;
    logic              out_valid_r, dllp_err_r;
    logic [DATA_W-1:0] out_data_r, rdata_s, load_data_s;
    logic [SEQ_W-1:0]  out_seq_r, load_seq_s;

    logic [7:0]        dllp_type_s;
    logic [SEQ_W-1:0]  dllp_seq_s, dllp_d_s;
    logic              is_ack_s, is_nak_s, err_s, purge_s, nak_start_s;
    logic [CW-1:0]     purge_cnt_s, cnt_p_s, off_p_s;
    logic              can_load_s, accept_s, load_s, start_s, expire_s, replay_go_s;
    logic              unused_s;

    assign can_load_s  = !out_valid_r || link_ready_i;
    assign tlp_ready_o = !rst && (state_r == NORMAL) && (count_r < CW'(DEPTH)) && can_load_s;
    assign accept_s    = tlp_valid_i && tlp_ready_o;
    assign unused_s    = ^dllp_i[DLLP_TYPE_LSB-1:SEQ_W];

    // DLLP decode, window check and post-purge view of the buffer
    always_comb begin
        dllp_type_s = dllp_i[DLLP_TYPE_LSB +: DLLP_TYPE_W];
        dllp_seq_s  = dllp_i[DLLP_SEQ_LSB +: SEQ_W];
        is_ack_s    = dllp_valid_i && (dllp_type_s == DLLP_ACK);
        is_nak_s    = dllp_valid_i && (dllp_type_s == DLLP_NAK);
        dllp_d_s    = dllp_seq_s - acked_seq_r;
        err_s       = (is_ack_s || is_nak_s) && (dllp_d_s > SEQ_W'(count_r));
        purge_s     = (is_ack_s || is_nak_s) && !err_s && (dllp_d_s != {SEQ_W{1'b0}});
        purge_cnt_s = purge_s ? CW'(dllp_d_s) : {CW{1'b0}};
        cnt_p_s     = count_r - purge_cnt_s;
        off_p_s     = (purge_cnt_s >= offset_r) ? {CW{1'b0}} : (offset_r - purge_cnt_s);
        rd_ptr_p_s  = rd_ptr_r + PW'(purge_cnt_s);
        acked_seq_n = purge_s ? dllp_seq_s : acked_seq_r;
        nak_start_s = is_nak_s && !err_s && (cnt_p_s != {CW{1'b0}});
    end

    assign raddr_s = rd_ptr_p_s + PW'(off_p_s);

    // next-state, replay sequencing and output-register load selection
    always_comb begin
        state_n      = state_r;
        offset_n     = off_p_s;
        timer_n      = timer_r;
        replay_num_n = purge_s ? {RW{1'b0}} : replay_num_r;
        start_s      = 1'b0;
        expire_s     = 1'b0;
        replay_go_s  = 1'b0;
        load_s       = 1'b0;
        load_data_s  = tlp_data_i;
        load_seq_s   = next_seq_r;
        count_n      = cnt_p_s + CW'(accept_s);
        case (state_r)
            NORMAL: begin
                if (nak_start_s) begin
                    start_s = 1'b1;
                end else if (purge_s || (cnt_p_s == {CW{1'b0}})) begin
                    timer_n = {TW{1'b0}};
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    expire_s = 1'b1;
                    start_s  = 1'b1;
                end else begin
                    timer_n = timer_r + TW'(1);
                end
                load_s = accept_s;
            end
            REPLAY: begin
                timer_n = {TW{1'b0}};
                if (nak_start_s) begin
                    start_s = 1'b1;
                end else begin
                    if (can_load_s && (off_p_s < cnt_p_s)) begin
                        load_s      = 1'b1;
                        load_data_s = rdata_s;
                        load_seq_s  = acked_seq_n + SEQ_W'(1) + SEQ_W'(off_p_s);
                        offset_n    = off_p_s + CW'(1);
                    end else begin
                        offset_n = off_p_s;
                    end
                    if (offset_n == cnt_p_s) begin
                        state_n = NORMAL;
                    end else begin
                        state_n = REPLAY;
                    end
                end
            end
            RETRAIN: begin
                timer_n = {TW{1'b0}};
                if (retrain_done_i) begin
                    replay_num_n = {RW{1'b0}};
                    offset_n     = {CW{1'b0}};
                    state_n      = (cnt_p_s != {CW{1'b0}}) ? REPLAY : NORMAL;
                end else begin
                    state_n = RETRAIN;
                end
            end
            default: begin
                state_n = NORMAL;
            end
        endcase
        // a NAK purges first, so replay_num may already be cleared here
        if (start_s) begin
            timer_n = {TW{1'b0}};
            if (replay_num_n == RW'(MAX_REPLAY)) begin
                state_n = RETRAIN;
            end else begin
                replay_num_n = replay_num_n + RW'(1);
                offset_n     = {CW{1'b0}};
                state_n      = REPLAY;
                replay_go_s  = 1'b1;
            end
        end else begin
            replay_go_s = 1'b0;
        end
    end

    // state, pointers, sequence tracking and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= NORMAL;
            next_seq_r   <= {SEQ_W{1'b0}};
            acked_seq_r  <= {SEQ_W{1'b1}};
            count_r      <= {CW{1'b0}};
            offset_r     <= {CW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            timer_r      <= {TW{1'b0}};
            replay_num_r <= {RW{1'b0}};
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            out_seq_r    <= {SEQ_W{1'b0}};
            dllp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            acked_seq_r  <= acked_seq_n;
            count_r      <= count_n;
            offset_r     <= offset_n;
            rd_ptr_r     <= rd_ptr_p_s;
            timer_r      <= timer_n;
            replay_num_r <= replay_num_n;
            dllp_err_r   <= err_s;
            if (accept_s) begin
                next_seq_r <= next_seq_r + SEQ_W'(1);
                wr_ptr_r   <= wr_ptr_r + PW'(1);
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= load_data_s;
                out_seq_r   <= load_seq_s;
            end else if (link_ready_i) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    pcie_replay_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (accept_s),
        .waddr (wr_ptr_r),
        .wdata (tlp_data_i),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign link_valid_o    = out_valid_r;
    assign link_data_o     = out_data_r;
    assign link_seq_o      = out_seq_r;
    assign dllp_err_o      = dllp_err_r;
    assign occupancy_o     = count_r;
    assign retrain_req_o   = (state_r == RETRAIN);
    assign replay_active_o = (state_r == REPLAY);

`ifdef PCIE_REPLAY_STAT_EN
    logic [15:0] replay_cnt_r, timeout_cnt_r;

    // saturating replay / timer-expiry statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            replay_cnt_r  <= 16'd0;
            timeout_cnt_r <= 16'd0;
        end else begin
            if (replay_go_s && (replay_cnt_r != 16'hFFFF)) begin
                replay_cnt_r <= replay_cnt_r + 16'd1;
            end
            if (expire_s && (timeout_cnt_r != 16'hFFFF)) begin
                timeout_cnt_r <= timeout_cnt_r + 16'd1;
            end
        end
    end

    assign replay_cnt_o  = replay_cnt_r;
    assign timeout_cnt_o = timeout_cnt_r;
`else
    logic unused_stat_s;
    assign unused_stat_s = expire_s ^ replay_go_s;
`endif

endmodule
